// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- host-to-device PS/2 command transmitter.
//
// Sends one byte from the FPGA to a PS/2 device over the shared open-drain
// clock/data pair. The block performs the sequence in this order:
//   1. Inhibit: hold PS2_CLK low.
//   2. Request-to-send: pull PS2_DATA low, which is the start bit.
//   3. Shift out the byte, then parity and stop, on device-generated clocks.
//   4. Check the device acknowledge.
// tx_busy lets the receive path ignore bus activity while a command is sent.
//
// Optional feature macro: PS2_TX_ACK_CHECK_EN
//   defined   -> a missing acknowledge on the ack clock pulses tx_err
//   undefined -> the ack-clock data sample is ignored; the frame ends in tx_done
//
// Parameters:
//   INHIBIT_CYCLES  cycles PS2_CLK is held low before request-to-send
//   TIMEOUT_CYCLES  max cycles between consecutive expected bus events
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   PS2_CLK   open-drain clock line (driven 0 or Z only)
//   PS2_DATA  open-drain data line (driven 0 or Z only)
//   tx_data   command byte, captured on accept
//   tx_valid  send request
//   tx_ready  can accept; a byte is taken when tx_valid && tx_ready
//   tx_busy   transmission in progress
//   tx_done   one-cycle pulse, frame acknowledged and bus idle again
//   tx_err    one-cycle pulse, timeout or missing acknowledge
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 1500000
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DATA,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE
    } state_t;

    state_t        state_reg, state_next;
    logic [8:0]    shift_reg, shift_next;      // {parity, data}
    logic [3:0]    bit_reg, bit_next;
    logic [IW-1:0] inh_reg, inh_next;
    logic [TW-1:0] to_reg, to_next;
    logic          data_low_reg, data_low_next;
    logic          done_reg, done_next;
    logic          err_reg, err_next;
    logic          clk_prev_reg;

    // Two-flop synchronizers: bit 0 is PS2_CLK, bit 1 is PS2_DATA.
    // Both reset to 1 so that no false falling edge is seen after reset.
    logic [1:0] pin_in;
    logic [1:0] sync_s;
    assign pin_in = {PS2_DATA, PS2_CLK};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic [1:0] stage_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) stage_reg <= 2'b11;
                else     stage_reg <= {stage_reg[0], pin_in[gi]};
            end
            assign sync_s[gi] = stage_reg[1];
        end
    endgenerate

    logic clk_s, data_s, fall, accept, timing;
    assign clk_s  = sync_s[0];
    assign data_s = sync_s[1];
    assign fall   = clk_prev_reg & ~clk_s;

    // tx_ready stays low during the done/err pulse cycle,
    // so ready rises the cycle after the pulse.
    assign tx_ready = (state_reg == IDLE) & ~done_reg & ~err_reg;
    assign tx_busy  = (state_reg != IDLE);
    assign tx_done  = done_reg;
    assign tx_err   = err_reg;
    assign accept   = tx_valid & tx_ready;

    // Open-drain: only ever pull low, otherwise release.
    assign PS2_CLK  = (state_reg == INHIBIT) ? 1'b0 : 1'bz;
    assign PS2_DATA = data_low_reg ? 1'b0 : 1'bz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            shift_reg    <= '0;
            bit_reg      <= '0;
            inh_reg      <= '0;
            to_reg       <= '0;
            data_low_reg <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            clk_prev_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            shift_reg    <= shift_next;
            bit_reg      <= bit_next;
            inh_reg      <= inh_next;
            to_reg       <= to_next;
            data_low_reg <= data_low_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
            clk_prev_reg <= clk_s;
        end
    end

    always_comb begin
        state_next    = state_reg;
        shift_next    = shift_reg;
        bit_next      = bit_reg;
        inh_next      = inh_reg;
        to_next       = to_reg;
        data_low_next = data_low_reg;
        done_next     = 1'b0;
        err_next      = 1'b0;
        timing        = (state_reg == RTS) || (state_reg == SEND) ||
                        (state_reg == ACK) || (state_reg == WAIT_IDLE);

        // Watchdog between device events: any falling clock edge restarts it.
        if (timing) begin
            if (fall) to_next = '0;
            else      to_next = to_reg + 1'b1;
        end

        if (timing && !fall && to_reg == TO_LAST) begin
            err_next      = 1'b1;
            state_next    = IDLE;
            data_low_next = 1'b0;
            to_next       = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    data_low_next = 1'b0;
                    if (accept) begin
                        state_next = INHIBIT;
                        shift_next = {~^tx_data, tx_data};
                        bit_next   = '0;
                        inh_next   = '0;
                    end
                end
                INHIBIT: begin
                    if (inh_reg == INH_LAST) begin
                        state_next    = RTS;
                        inh_next      = '0;
                        to_next       = '0;
                        data_low_next = 1'b1;   // start bit
                    end else begin
                        inh_next = inh_reg + 1'b1;
                    end
                end
                RTS: begin
                    // The start bit is held through the first device clock.
                    if (fall) state_next = SEND;
                end
                SEND: begin
                    if (fall) begin
                        if (bit_reg == 4'd9) begin
                            data_low_next = 1'b0;   // stop bit: release
                            state_next    = ACK;
                        end else begin
                            data_low_next = ~shift_reg[bit_reg];
                            bit_next      = bit_reg + 1'b1;
                        end
                    end
                end
                ACK: begin
                    if (fall) begin
`ifdef PS2_TX_ACK_CHECK_EN
                        if (!data_s) begin
                            state_next = WAIT_IDLE;
                        end else begin
                            err_next   = 1'b1;
                            state_next = IDLE;
                        end
`else
                        state_next = WAIT_IDLE;
`endif
                    end
                end
                WAIT_IDLE: begin
                    if (clk_s && data_s) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

    localparam int INH  = 120;
    localparam int TO   = 5000;
    localparam int HALF = 20;      // device half clock period, in clk cycles

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    wire        tx_ready, tx_busy, tx_done, tx_err;
    wire        ps2_clk, ps2_data;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    pullup (ps2_clk);
    pullup (ps2_data);
    assign ps2_clk  = dev_clk_low  ? 1'b0 : 1'bz;
    assign ps2_data = dev_data_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int done_seen = 0, err_seen = 0, both_seen = 0;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err)
    );

    // Count every high cycle of the pulses; one-cycle pulses add exactly 1.
    always @(negedge clk) begin
        if (tx_done === 1'b1) done_seen++;
        if (tx_err === 1'b1) err_seen++;
        if (tx_done === 1'b1 && tx_err === 1'b1) both_seen++;
    end

    // Present a byte, then measure how many samples PS2_CLK is held low.
    // Returns at the first sample after the inhibit phase.
    task automatic start_tx(input logic [7:0] b, output int inh_cnt,
                            output logic rdy_first, output logic busy_first);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid   = 1'b0;
        rdy_first  = tx_ready;
        busy_first = tx_busy;
        inh_cnt = 0;
        while (ps2_clk === 1'b0 && inh_cnt < INH * 4) begin
            inh_cnt++;
            @(negedge clk);
        end
    endtask

    // Device generates n clocks and samples data just before each rising edge.
    task automatic device_clocks(input int n, output logic [10:0] frame);
        frame = '1;
        for (int i = 0; i < n; i++) begin
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            frame[i] = ps2_data;
            dev_clk_low = 1'b0;
        end
    endtask

    task automatic device_ack(input bit ack);
        repeat (5) @(negedge clk);
        dev_data_low = ack;
        repeat (HALF - 5) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (3) @(negedge clk);
        dev_data_low = 1'b0;
    endtask

    task automatic test_reset;
        int bad_lines, bad_status, p0;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        vectors++;
        if (ps2_clk !== 1'b1 || ps2_data !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold: clk=%b data=%b ready=%b busy=%b required 1 1 1 0",
                     ps2_clk, ps2_data, tx_ready, tx_busy);
        end
        rst = 1'b0;
        bad_lines = 0;
        bad_status = 0;
        p0 = done_seen + err_seen;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (ps2_clk !== 1'b1 || ps2_data !== 1'b1) bad_lines++;
            if (tx_ready !== 1'b1 || tx_busy !== 1'b0) bad_status++;
        end
        vectors++;
        if (bad_lines != 0) begin
            miscompares++;
            $display("FAIL reset_lines: %0d cycles with a line driven, required 0", bad_lines);
        end
        vectors++;
        if (bad_status != 0) begin
            miscompares++;
            $display("FAIL reset_status: %0d cycles not ready/idle, required 0", bad_status);
        end
        vectors++;
        #1;
        if (done_seen + err_seen != p0) begin
            miscompares++;
            $display("FAIL reset_pulses: %0d pulses, required 0", done_seen + err_seen - p0);
        end
    endtask

    // Full frame against the device model; the expected frame is built from the
    // protocol rules: start 0, data LSB first, odd parity, stop 1.
    task automatic test_frame(input logic [7:0] b, input bit ack);
        int inh, d0, e0, b0, wait_cnt;
        logic rdy1, busy1, exp_par, exp_done;
        logic [10:0] frame;
        exp_par  = ($countones(b) % 2 == 0);
`ifdef PS2_TX_ACK_CHECK_EN
        exp_done = ack;
`else
        exp_done = 1'b1;
`endif
        #1;
        d0 = done_seen; e0 = err_seen; b0 = both_seen;
        start_tx(b, inh, rdy1, busy1);
        vectors++;
        if (rdy1 !== 1'b0 || busy1 !== 1'b1) begin
            miscompares++;
            $display("FAIL frame_%h_busy: ready=%b busy=%b required 0 1", b, rdy1, busy1);
        end
        vectors++;
        if (inh != INH) begin
            miscompares++;
            $display("FAIL frame_%h_inhibit: clk low %0d cycles, required %0d", b, inh, INH);
        end
        vectors++;
        if (ps2_data !== 1'b0 || ps2_clk !== 1'b1) begin
            miscompares++;
            $display("FAIL frame_%h_rts: data=%b clk=%b required 0 1", b, ps2_data, ps2_clk);
        end
        device_clocks(11, frame);
        vectors++;
        if (frame[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_%h_start: got %b required 0", b, frame[0]);
        end
        vectors++;
        if (frame[8:1] !== b) begin
            miscompares++;
            $display("FAIL frame_%h_data: got %h required %h", b, frame[8:1], b);
        end
        vectors++;
        if (frame[9] !== exp_par) begin
            miscompares++;
            $display("FAIL frame_%h_parity: got %b required %b", b, frame[9], exp_par);
        end
        vectors++;
        if (frame[10] !== 1'b1) begin
            miscompares++;
            $display("FAIL frame_%h_stop: got %b required 1", b, frame[10]);
        end
        device_ack(ack);
        wait_cnt = 0;
        #1;
        while (done_seen + err_seen == d0 + e0 && wait_cnt < 300) begin
            @(negedge clk);
            #1;
            wait_cnt++;
        end
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (done_seen - d0 != int'(exp_done) || err_seen - e0 != int'(!exp_done)) begin
            miscompares++;
            $display("FAIL frame_%h_result: done=%0d err=%0d required done=%0d err=%0d",
                     b, done_seen - d0, err_seen - e0, exp_done, !exp_done);
        end
        vectors++;
        if (both_seen != b0) begin
            miscompares++;
            $display("FAIL frame_%h_both: %0d cycles with done and err, required 0", b, both_seen - b0);
        end
        vectors++;
        if (tx_ready !== 1'b1 || tx_busy !== 1'b0 || ps2_clk !== 1'b1 || ps2_data !== 1'b1) begin
            miscompares++;
            $display("FAIL frame_%h_end: ready=%b busy=%b clk=%b data=%b required 1 0 1 1",
                     b, tx_ready, tx_busy, ps2_clk, ps2_data);
        end
        $display("frame %h ack=%0d parity=%b done=%0d err=%0d", b, ack, frame[9],
                 done_seen - d0, err_seen - e0);
    endtask

    task automatic test_timeout;
        int inh, cnt;
        logic rdy1, busy1;
        logic [7:0] b;
        b = 8'($urandom);
        start_tx(b, inh, rdy1, busy1);
        vectors++;
        if (inh != INH) begin
            miscompares++;
            $display("FAIL timeout_inhibit: clk low %0d cycles, required %0d", inh, INH);
        end
        // Sample 0 is the first RTS cycle; the device never clocks.
        cnt = 0;
        while (tx_err !== 1'b1 && cnt < TO + 100) begin
            @(negedge clk);
            cnt++;
        end
        vectors++;
        if (cnt != TO) begin
            miscompares++;
            $display("FAIL timeout_latency: err after %0d cycles, required %0d", cnt, TO);
        end
        vectors++;
        if (ps2_clk !== 1'b1 || ps2_data !== 1'b1 || tx_done !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_lines: clk=%b data=%b done=%b required 1 1 0",
                     ps2_clk, ps2_data, tx_done);
        end
        @(negedge clk);
        vectors++;
        if (tx_ready !== 1'b1 || tx_err !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_ready: ready=%b err=%b required 1 0", tx_ready, tx_err);
        end
        $display("timeout byte %h err after %0d cycles", b, cnt);
    endtask

    task automatic test_reset_mid_send;
        int inh, p0, busy_cnt;
        logic rdy1, busy1;
        logic [7:0] b;
        logic [10:0] frame;
        b = 8'($urandom) & 8'hEF;          // bit 4 is 0 so the host pulls data low
        start_tx(b, inh, rdy1, busy1);
        tx_data  = ~b;
        tx_valid = 1'b1;                   // request while busy must be dropped
        device_clocks(6, frame);
        repeat (2) @(negedge clk);
        vectors++;
        if (ps2_data !== 1'b0 || tx_busy !== 1'b1 || tx_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_bit4: data=%b busy=%b ready=%b required 0 1 0",
                     ps2_data, tx_busy, tx_ready);
        end
        tx_valid = 1'b0;
        #1;
        p0 = done_seen + err_seen;
        @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if (ps2_data !== 1'b1 || ps2_clk !== 1'b1 || tx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_release: data=%b clk=%b busy=%b required 1 1 0",
                     ps2_data, ps2_clk, tx_busy);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_busy !== 1'b0) busy_cnt++;
        end
        #1;
        vectors++;
        if (busy_cnt != 0 || done_seen + err_seen != p0) begin
            miscompares++;
            $display("FAIL rst_no_queue: busy %0d cycles, %0d pulses, required 0 0",
                     busy_cnt, done_seen + err_seen - p0);
        end
        $display("reset mid-send byte %h released", b);
        test_frame(8'($urandom), 1'b1);
    endtask

    initial begin
        test_reset();
        test_frame(8'hED, 1'b1);
        test_frame(8'hF4, 1'b1);
        test_frame(8'hFF, 1'b1);
        for (int i = 0; i < 4; i++) test_frame(8'($urandom), 1'b1);
        test_frame(8'($urandom), 1'b0);
        test_timeout();
        test_reset_mid_send();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
